// File: rtl/period_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : period_check                                               |
// | Description : Measures the period of an asynchronous reference clock     |
// |               (clk_in) in clk cycles, declares it stable after a run of  |
// |               matching measurements, and flags loss of clk_in.           |
// | Ports       : clk           - sampling clock, rising edge               |
// |               RST           - synchronous active-high reset             |
// |               PWRDWN        - power-down, holds block idle              |
// |               clk_in        - monitored reference clock (async)         |
// |               ref_period    - accepted period in clk cycles             |
// |               period_stable - ref_period is trustworthy                 |
// |               new_meas      - 1-cycle pulse per completed measurement   |
// |               timeout       - 1-cycle pulse when clk_in is lost         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module period_check #(
  parameter int unsigned STABLE_COUNT = 4,
  parameter int unsigned TOLERANCE    = 1,
  parameter int unsigned MAX_PERIOD   = 65535
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        PWRDWN,
  input  logic        clk_in,
  output logic [31:0] ref_period,
  output logic        period_stable,
  output logic        new_meas,
  output logic        timeout
);

  localparam logic [31:0] c_stable_count = 32'(STABLE_COUNT);
  localparam logic [31:0] c_tolerance    = 32'(TOLERANCE);
  localparam logic [31:0] c_max_period   = 32'(MAX_PERIOD);

  typedef enum logic [1:0] {
    S_WAIT_EDGE = 2'd0,
    S_ACQUIRE   = 2'd1,
    S_STABLE    = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic [31:0] r_cnt;
  logic [31:0] r_run;
  logic [31:0] r_cand;
  logic        r_stable;
  logic        r_new_meas;
  logic        r_timeout;

  logic        w_edge;
  logic [31:0] w_diff;
  logic        w_match;
  logic [31:0] w_run_inc;
  logic        w_cnt_max;

  // The synchroniser latency is identical for every edge, so it cancels
  // out of the edge-to-edge distance held in r_cnt.
  assign w_edge = r_sync2 & ~r_sync3;

  always_comb begin
    // Larger minus smaller keeps the difference free of unsigned wrap.
    w_diff    = (r_cnt >= r_cand) ? (r_cnt - r_cand) : (r_cand - r_cnt);
    w_match   = (w_diff <= c_tolerance);
    w_run_inc = r_run + 32'd1;
    w_cnt_max = (r_cnt == c_max_period);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= S_WAIT_EDGE;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
      r_cnt      <= 32'd0;
      r_run      <= 32'd0;
      r_cand     <= 32'd0;
      r_stable   <= 1'b0;
      r_new_meas <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_sync1    <= clk_in;
      r_sync2    <= r_sync1;
      r_sync3    <= r_sync2;
      r_new_meas <= 1'b0;
      r_timeout  <= 1'b0;

      if (PWRDWN) begin
        r_state  <= S_WAIT_EDGE;
        r_cnt    <= 32'd0;
        r_run    <= 32'd0;
        r_cand   <= 32'd0;
        r_stable <= 1'b0;
      end else begin
        r_cnt <= w_edge ? 32'd1 : (r_cnt + 32'd1);

        case (r_state)
          S_WAIT_EDGE: begin
            // First edge only opens the measurement window.
            if (w_edge) begin
              r_state <= S_ACQUIRE;
              r_run   <= 32'd0;
            end
          end

          S_ACQUIRE: begin
            if (w_edge) begin
              r_new_meas <= 1'b1;
              if ((r_run == 32'd0) || !w_match) begin
                r_cand <= r_cnt;
                r_run  <= 32'd1;
              end else begin
                r_run <= w_run_inc;
                if (w_run_inc == c_stable_count) begin
                  r_state  <= S_STABLE;
                  r_stable <= 1'b1;
                end
              end
            end else if (w_cnt_max) begin
              r_state   <= S_WAIT_EDGE;
              r_stable  <= 1'b0;
              r_cand    <= 32'd0;
              r_run     <= 32'd0;
              r_timeout <= 1'b1;
            end
          end

          S_STABLE: begin
            if (w_edge) begin
              r_new_meas <= 1'b1;
              // A mismatch restarts acquisition with this measurement as
              // the new candidate, so ref_period never drops to zero here.
              if (!w_match) begin
                r_state  <= S_ACQUIRE;
                r_stable <= 1'b0;
                r_cand   <= r_cnt;
                r_run    <= 32'd1;
              end
            end else if (w_cnt_max) begin
              r_state   <= S_WAIT_EDGE;
              r_stable  <= 1'b0;
              r_cand    <= 32'd0;
              r_run     <= 32'd0;
              r_timeout <= 1'b1;
            end
          end

          default: begin
            r_state  <= S_WAIT_EDGE;
            r_stable <= 1'b0;
            r_cand   <= 32'd0;
            r_run    <= 32'd0;
          end
        endcase
      end
    end
  end

  assign ref_period    = r_cand;
  assign period_stable = r_stable;
  assign new_meas      = r_new_meas;
  assign timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_period_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_period_check                                            |
// | Description : Scoreboard bench for period_check. Stimulus drives clk_in  |
// |               with chosen rise-to-rise gaps and pushes the expected      |
// |               event per rise; a monitor pops on new_meas/timeout.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_period_check;

  localparam int SC  = 4;
  localparam int TOL = 1;
  localparam int MAX = 100;

  logic        clk;
  logic        RST;
  logic        PWRDWN;
  logic        clk_in;
  logic [31:0] ref_period;
  logic        period_stable;
  logic        new_meas;
  logic        timeout;

  period_check #(
    .STABLE_COUNT (SC),
    .TOLERANCE    (TOL),
    .MAX_PERIOD   (MAX)
  ) dut (
    .clk           (clk),
    .RST           (RST),
    .PWRDWN        (PWRDWN),
    .clk_in        (clk_in),
    .ref_period    (ref_period),
    .period_stable (period_stable),
    .new_meas      (new_meas),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_to;
    int ref_p;
    bit stb;
    bit chk_dist;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model: mode 0 = waiting for first rise, 1 = acquiring,
  // 2 = stable. Works directly on rise-to-rise gaps in clk cycles.
  int  m_mode     = 0;
  int  m_run      = 0;
  int  m_cand     = 0;
  int  m_last_gap = 0;
  bit  m_prev_evt = 0;

  function automatic void model_reset();
    m_mode = 0; m_run = 0; m_cand = 0; m_prev_evt = 0;
  endfunction

  function automatic void model_edge(int gap);
    ev_t e;
    int  d;
    if (m_mode == 0) begin
      m_mode = 1; m_run = 0; m_prev_evt = 0;
      return;
    end
    d = gap - m_cand;
    if (d < 0) d = -d;
    if (m_mode == 1) begin
      if (m_run == 0 || d > TOL) begin
        m_cand = gap; m_run = 1;
      end else begin
        m_run++;
      end
      if (m_run == SC) m_mode = 2;
    end else if (d > TOL) begin
      m_mode = 1; m_cand = gap; m_run = 1;
    end
    e.is_to = 0; e.ref_p = m_cand; e.stb = (m_mode == 2); e.chk_dist = 0;
    q.push_back(e);
    m_prev_evt = 1;
  endfunction

  function automatic void model_timeout();
    ev_t e;
    e.is_to = 1; e.ref_p = 0; e.stb = 0; e.chk_dist = m_prev_evt;
    q.push_back(e);
    model_reset();
  endfunction

  // Rise clk_in now, then keep the next rise g cycles away.
  task automatic rise(int g);
    int h;
    @(negedge clk);
    clk_in = 1'b1;
    model_edge(m_last_gap);
    if (g > MAX && m_mode != 0) model_timeout();
    m_last_gap = g;
    h = $urandom_range(1, g - 1);
    repeat (h) @(negedge clk);
    clk_in = 1'b0;
    repeat (g - h - 1) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expected events never appeared, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor
  int cyc = 0;
  int last_meas_cyc = 0;
  int held_ref = 0;
  bit held_stb = 0;

  always @(posedge clk) begin
    ev_t e;
    #1;
    cyc++;
    if (RST || PWRDWN) begin
      n_cmp++;
      if (ref_period != 0 || period_stable || new_meas || timeout) begin
        n_bad++;
        $display("FAIL idle_zero: ref=%0d stb=%0b nm=%0b to=%0b, required all 0",
                 ref_period, period_stable, new_meas, timeout);
      end
      held_ref = 0; held_stb = 0;
    end else begin
      if (new_meas && timeout) begin
        n_cmp++; n_bad++;
        $display("FAIL both_pulses: new_meas and timeout together, required exclusive");
      end
      if (new_meas || timeout) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_event: nm=%0b to=%0b ref=%0d, required no event",
                   new_meas, timeout, ref_period);
        end else begin
          e = q.pop_front();
          n_cmp++;
          if (timeout != e.is_to || ref_period != 32'(e.ref_p) || period_stable != e.stb) begin
            n_bad++;
            $display("FAIL event: to=%0b ref=%0d stb=%0b, required to=%0b ref=%0d stb=%0b",
                     timeout, ref_period, period_stable, e.is_to, e.ref_p, e.stb);
          end
          if (e.is_to && e.chk_dist) begin
            n_cmp++;
            if (cyc - last_meas_cyc != MAX) begin
              n_bad++;
              $display("FAIL timeout_dist: %0d cycles after last measurement, required %0d",
                       cyc - last_meas_cyc, MAX);
            end
          end
          held_ref = e.ref_p; held_stb = e.stb;
        end
        if (new_meas) last_meas_cyc = cyc;
      end
      n_cmp++;
      if (ref_period != 32'(held_ref) || period_stable != held_stb) begin
        n_bad++;
        $display("FAIL hold: ref=%0d stb=%0b, required ref=%0d stb=%0b",
                 ref_period, period_stable, held_ref, held_stb);
      end
      if (period_stable && ref_period == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL stable_zero: period_stable=1 with ref_period=0, required ref_period!=0");
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g, r;
    RST = 1'b1; PWRDWN = 1'b0; clk_in = 1'b0;
    repeat (4) @(negedge clk);
    RST = 1'b0;
    repeat (3) @(negedge clk);

    // Constant period 10, then tolerated jitter, then drift.
    repeat (6) rise(10);
    rise(11); rise(9); rise(11);
    rise(10); rise(11); rise(12); rise(13);
    // Period switch to 20.
    repeat (6) rise(20);
    // Loss of clk_in, then recovery and an edge landing exactly at MAX.
    rise(150);
    repeat (6) rise(10);
    rise(MAX);
    rise(10);
    drain();

    // Reset pulse while stable.
    repeat (6) rise(10);
    drain();
    @(negedge clk); RST = 1'b1;
    @(negedge clk); RST = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // Power-down for 50 cycles with clk_in toggling, then re-acquire.
    repeat (6) rise(10);
    drain();
    @(negedge clk); PWRDWN = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      clk_in = (i < 40) && ((i % 10) < 5);
    end
    PWRDWN = 1'b0;
    model_reset();
    repeat (6) rise(12);
    drain();

    // Reset with an edge in flight must not produce a measurement.
    @(negedge clk); clk_in = 1'b1;
    @(negedge clk); clk_in = 1'b0; RST = 1'b1;
    repeat (3) @(negedge clk);
    RST = 1'b0;
    model_reset();
    repeat (5) rise(15);
    drain();

    // Randomised bursts around a base period.
    for (int b = 0; b < 25; b++) begin
      base = $urandom_range(4, 30);
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      g = base;
        else if (r < 8) g = base + $urandom_range(0, 4) - 2;
        else            g = base + $urandom_range(3, 12);
        if (g < 2) g = 2;
        rise(g);
      end
      r = $urandom_range(0, 3);
      if (r == 0)      rise(MAX);
      else if (r == 1) rise(MAX + 1 + $urandom_range(0, 20));
    end
    rise(150);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
